// File: rtl/morse_emisor_pkg.sv
// Shared definitions for the Morse keying engine: FSM states, code map constants, ROM entry type.
// MORSE_DIGITS_EN extends the valid code range to include digits 0-9.
package morse_emisor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ON      = 3'd2,
        ST_GAP     = 3'd3,
        ST_END_GAP = 3'd4,
        ST_FIN     = 3'd5
    } state_e;

    localparam int MAX_SYMBOLS = 5;

    localparam logic [5:0] CODE_A    = 6'd0;
    localparam logic [5:0] CODE_DIG0 = 6'd26;
`ifdef MORSE_DIGITS_EN
    localparam logic [5:0] CODE_MAX  = 6'd35;
`else
    localparam logic [5:0] CODE_MAX  = 6'd25;
`endif

    // Pattern is left-aligned: the first symbol sits in the MSB, 1 = dash.
    typedef struct packed {
        logic                   valid;
        logic [2:0]             len;
        logic [MAX_SYMBOLS-1:0] pat;
    } morse_sym_t;

    function automatic morse_sym_t mk_sym(input logic [2:0] len, input logic [MAX_SYMBOLS-1:0] pat);
        morse_sym_t s;
        s.valid = 1'b1;
        s.len   = len;
        s.pat   = pat;
        return s;
    endfunction

endpackage

// File: rtl/morse_emisor_rom.sv
// Combinational character-code to Morse pattern lookup (VALID, LEN, left-aligned PAT).
// Digits 0-9 are present only when MORSE_DIGITS_EN is defined.
module morse_emisor_rom
    import morse_emisor_pkg::*;
(
    input  logic [5:0] i_code,
    output morse_sym_t o_sym
);

    logic [5:0] w_letter;
    assign w_letter = i_code - CODE_A;

`ifdef MORSE_DIGITS_EN
    logic [5:0] w_digit;
    assign w_digit = i_code - CODE_DIG0;
`endif

    always_comb begin
        o_sym = '0;
        if (i_code <= CODE_MAX) begin
            if (i_code < CODE_DIG0) begin
                case (w_letter)
                    6'd0:    o_sym = mk_sym(3'd2, 5'b01000); // A .-
                    6'd1:    o_sym = mk_sym(3'd4, 5'b10000); // B -...
                    6'd2:    o_sym = mk_sym(3'd4, 5'b10100); // C -.-.
                    6'd3:    o_sym = mk_sym(3'd3, 5'b10000); // D -..
                    6'd4:    o_sym = mk_sym(3'd1, 5'b00000); // E .
                    6'd5:    o_sym = mk_sym(3'd4, 5'b00100); // F ..-.
                    6'd6:    o_sym = mk_sym(3'd3, 5'b11000); // G --.
                    6'd7:    o_sym = mk_sym(3'd4, 5'b00000); // H ....
                    6'd8:    o_sym = mk_sym(3'd2, 5'b00000); // I ..
                    6'd9:    o_sym = mk_sym(3'd4, 5'b01110); // J .---
                    6'd10:   o_sym = mk_sym(3'd3, 5'b10100); // K -.-
                    6'd11:   o_sym = mk_sym(3'd4, 5'b01000); // L .-..
                    6'd12:   o_sym = mk_sym(3'd2, 5'b11000); // M --
                    6'd13:   o_sym = mk_sym(3'd2, 5'b10000); // N -.
                    6'd14:   o_sym = mk_sym(3'd3, 5'b11100); // O ---
                    6'd15:   o_sym = mk_sym(3'd4, 5'b01100); // P .--.
                    6'd16:   o_sym = mk_sym(3'd4, 5'b11010); // Q --.-
                    6'd17:   o_sym = mk_sym(3'd3, 5'b01000); // R .-.
                    6'd18:   o_sym = mk_sym(3'd3, 5'b00000); // S ...
                    6'd19:   o_sym = mk_sym(3'd1, 5'b10000); // T -
                    6'd20:   o_sym = mk_sym(3'd3, 5'b00100); // U ..-
                    6'd21:   o_sym = mk_sym(3'd4, 5'b00010); // V ...-
                    6'd22:   o_sym = mk_sym(3'd3, 5'b01100); // W .--
                    6'd23:   o_sym = mk_sym(3'd4, 5'b10010); // X -..-
                    6'd24:   o_sym = mk_sym(3'd4, 5'b10110); // Y -.--
                    6'd25:   o_sym = mk_sym(3'd4, 5'b11000); // Z --..
                    default: o_sym = '0;
                endcase
            end
`ifdef MORSE_DIGITS_EN
            else begin
                case (w_digit)
                    6'd0:    o_sym = mk_sym(3'd5, 5'b11111);
                    6'd1:    o_sym = mk_sym(3'd5, 5'b01111);
                    6'd2:    o_sym = mk_sym(3'd5, 5'b00111);
                    6'd3:    o_sym = mk_sym(3'd5, 5'b00011);
                    6'd4:    o_sym = mk_sym(3'd5, 5'b00001);
                    6'd5:    o_sym = mk_sym(3'd5, 5'b00000);
                    6'd6:    o_sym = mk_sym(3'd5, 5'b10000);
                    6'd7:    o_sym = mk_sym(3'd5, 5'b11000);
                    6'd8:    o_sym = mk_sym(3'd5, 5'b11100);
                    6'd9:    o_sym = mk_sym(3'd5, 5'b11110);
                    default: o_sym = '0;
                endcase
            end
`endif
        end
    end

endmodule

// File: rtl/morse_emisor.sv
// Character-to-Morse keying engine timed by the divider toggle (each CLK_2 edge = one unit).
// Build option MORSE_DIGITS_EN enables digit codes 26-35 in the lookup ROM.
module morse_emisor
    import morse_emisor_pkg::*;
#(
    parameter int DASH_UNITS = 3,
    parameter int SYM_GAP    = 1,
    parameter int LETTER_GAP = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CLK_2,
    input  logic       START,
    input  logic [5:0] CODE,
    output logic       MORSE,
    output logic       BUSY,
    output logic       DONE,
    output state_e     DBG_STATE
);

    localparam int CNT_MAX0 = (DASH_UNITS > LETTER_GAP) ? DASH_UNITS : LETTER_GAP;
    localparam int CNT_MAX  = (CNT_MAX0 > SYM_GAP) ? CNT_MAX0 : SYM_GAP;
    localparam int CNT_W    = ($clog2(CNT_MAX + 1) > 3) ? $clog2(CNT_MAX + 1) : 3;

    localparam logic [CNT_W-1:0] DASH_L   = CNT_W'(DASH_UNITS);
    localparam logic [CNT_W-1:0] SYM_L    = CNT_W'(SYM_GAP);
    localparam logic [CNT_W-1:0] LETTER_L = CNT_W'(LETTER_GAP);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W:0]   CNT_ONE_X = (CNT_W + 1)'(1);

    state_e                 r_state;
    state_e                 w_next;
    logic                   r_prev;
    logic                   w_tick;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_dur;
    logic [CNT_W-1:0]       w_target;
    logic [CNT_W-1:0]       w_new_dur;
    logic [MAX_SYMBOLS-1:0] r_pat;
    logic [2:0]             r_len;
    logic                   r_morse;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_accept;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_hit;
    logic                   w_counting;
    morse_sym_t             w_sym;

    morse_emisor_rom u_rom (
        .i_code (CODE),
        .o_sym  (w_sym)
    );

    assign w_tick     = CLK_2 ^ r_prev;
    assign w_counting = (r_state == ST_ON) || (r_state == ST_GAP) || (r_state == ST_END_GAP);
    assign w_new_dur  = r_pat[MAX_SYMBOLS-1] ? DASH_L : CNT_ONE;

    always_comb begin
        w_target = CNT_SAT;
        case (r_state)
            ST_ON:      w_target = r_dur;
            ST_GAP:     w_target = SYM_L;
            ST_END_GAP: w_target = LETTER_L;
            default:    w_target = CNT_SAT;
        endcase
    end

    // The tick that causes a state entry is consumed by it; r_cnt counts only later ticks.
    assign w_hit = w_tick && (({1'b0, r_cnt} + CNT_ONE_X) >= {1'b0, w_target});

    // START is a request without ready: it is taken only in IDLE with BUSY low, else dropped.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_rise   = 1'b0;
        w_fall   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START && !r_busy) begin
                    w_accept = 1'b1;
                    w_next   = w_sym.valid ? ST_LOAD : ST_FIN;
                end
            end
            ST_LOAD: begin
                if (w_tick) begin
                    w_rise = 1'b1;
                    w_next = ST_ON;
                end
            end
            ST_ON: begin
                if (w_hit) begin
                    w_fall = 1'b1;
                    w_next = (r_len > 3'd1) ? ST_GAP : ST_END_GAP;
                end
            end
            ST_GAP: begin
                if (w_hit) begin
                    w_rise = 1'b1;
                    w_next = ST_ON;
                end
            end
            ST_END_GAP: begin
                if (w_hit) begin
                    w_next = ST_FIN;
                end
            end
            ST_FIN: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_prev  <= 1'b0;
            r_cnt   <= '0;
            r_dur   <= '0;
            r_pat   <= '0;
            r_len   <= '0;
            r_morse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_prev <= CLK_2;

            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_counting && w_tick && (r_cnt != CNT_SAT)) begin
                r_cnt <= r_cnt + CNT_ONE;
            end

            if (w_accept) begin
                r_pat <= w_sym.pat;
                r_len <= w_sym.len;
            end else if (w_fall) begin
                r_pat <= {r_pat[MAX_SYMBOLS-2:0], 1'b0};
                r_len <= r_len - 3'd1;
            end

            if (w_rise) begin
                r_dur   <= w_new_dur;
                r_morse <= 1'b1;
            end else if (w_fall) begin
                r_morse <= 1'b0;
            end

            // DONE trails the FIN state by one cycle; BUSY drops together with DONE.
            r_done <= (r_state == ST_FIN);
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign MORSE     = r_morse;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign DBG_STATE = r_state;

endmodule
